// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the mproc program-memory loader.
// Contents:
//   PML_AW / PML_DW / PML_DEPTH : default geometry of the program store
//   COUNT_ZERO_MEANS            : word count implied by a count byte of zero
//   state_e                     : 3-bit loader FSM encoding (IDLE..ERR)
//   accepts_byte()              : states in which the loader takes host bytes
package prog_mem_loader_pkg;

   localparam int unsigned PML_AW           = 7;
   localparam int unsigned PML_DW           = 16;
   localparam int unsigned PML_DEPTH        = 128;
   localparam int unsigned COUNT_ZERO_MEANS = 128;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCount = 3'd1,
      StHi    = 3'd2,
      StLo    = 3'd3,
      StChk   = 3'd4,
      StRun   = 3'd5,
      StErr   = 3'd6
   } state_e;

   function automatic logic accepts_byte(input state_e s);
      return (s == StCount) || (s == StHi) || (s == StLo) || (s == StChk);
   endfunction

endpackage

// File: rtl/mem_array_128x16.sv
// Program/data store: one registered write port, one combinational read port.
// Ports:
//   clk    : write clock
//   reset  : asynchronous active-low; clears every word to zero
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
module mem_array_128x16 #(
   parameter int unsigned AW = 7,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int unsigned Depth = 1 << AW;

   logic [DW-1:0] mem_q [Depth];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Memory-side responder for the 16-bit mproc bus with a byte-serial boot loader.
// Frame: count byte N (0 means 128), 2N data bytes high-first into words 0..N-1,
// then an XOR checksum of the data bytes. The processor is held in reset until a
// frame completes with a matching checksum.
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   cpu_addr   : processor address;  cpu_data : combinational read data
//   cpu_rst_n  : active-low processor reset, high only after a good load
//   ld_start   : begin/restart a load (wins over a same-edge byte)
//   ld_valid, ld_byte, ld_ready : host byte handshake
//   ld_done    : load finished OK;  ld_err : checksum mismatch
module prog_mem_loader
   import prog_mem_loader_pkg::*;
#(
   parameter int unsigned AW    = PML_AW,
   parameter int unsigned DW    = PML_DW,
   parameter int unsigned DEPTH = PML_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] cpu_addr,
   output logic [DW-1:0] cpu_data,
   output logic          cpu_rst_n,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [7:0]    ld_byte,
   output logic          ld_ready,
   output logic          ld_done,
   output logic          ld_err
);

   // One extra bit so a count of DEPTH compares without wrapping.
   localparam int unsigned CntW = AW + 1;

   state_e            state_q, state_d;
   logic [CntW-1:0]   wptr_q, wptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        chk_q, chk_d;
   logic [7:0]        hi_q, hi_d;
   logic              ready_q, ready_d;
   logic              rst_n_q, rst_n_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              xfer;
   logic              mem_we;

   mem_array_128x16 #(
      .AW (AW),
      .DW (DW)
   ) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .waddr (wptr_q[AW-1:0]),
      .wdata ({hi_q, ld_byte}),
      .raddr (cpu_addr),
      .rdata (cpu_data)
   );

   // ready_q always mirrors accepts_byte(state_q), so this is the transfer strobe.
   assign xfer = ld_valid & ready_q;

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      chk_d   = chk_q;
      hi_d    = hi_q;
      mem_we  = 1'b0;

      if (ld_start) begin
         state_d = StCount;
         wptr_d  = '0;
         chk_d   = '0;
      end else if (xfer) begin
         unique case (state_q)
            StCount: begin
               cnt_d   = (ld_byte == 8'h00) ? CntW'(COUNT_ZERO_MEANS) : CntW'(ld_byte);
               state_d = StHi;
            end
            StHi: begin
               hi_d    = ld_byte;
               chk_d   = chk_q ^ ld_byte;
               state_d = StLo;
            end
            StLo: begin
               mem_we  = 1'b1;
               chk_d   = chk_q ^ ld_byte;
               wptr_d  = wptr_q + CntW'(1);
               state_d = ((wptr_q + CntW'(1)) == cnt_q) ? StChk : StHi;
            end
            StChk: begin
               state_d = (ld_byte == chk_q) ? StRun : StErr;
            end
            default: ;
         endcase
      end

      // Status outputs lag the state by one edge; ld_start clears them at once.
      ready_d = accepts_byte(state_d);
      rst_n_d = !ld_start && (state_q == StRun);
      done_d  = !ld_start && (state_q == StRun);
      err_d   = !ld_start && (state_q == StErr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         wptr_q  <= '0;
         cnt_q   <= '0;
         chk_q   <= '0;
         hi_q    <= '0;
         ready_q <= 1'b0;
         rst_n_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
         chk_q   <= chk_d;
         hi_q    <= hi_d;
         ready_q <= ready_d;
         rst_n_q <= rst_n_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign ld_ready  = ready_q;
   assign cpu_rst_n = rst_n_q;
   assign ld_done   = done_q;
   assign ld_err    = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: frame loads, checksum error, full 128-word
// frame, handshake gaps, restart collision and asynchronous reset mid-load.
module tb_prog_mem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  cpu_addr;
   logic [15:0] cpu_data;
   logic        cpu_rst_n;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_ready;
   logic        ld_done;
   logic        ld_err;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      int          stage;
      logic [6:0]  addr;
      logic [15:0] data;
   } rd_vec_t;

   rd_vec_t     tbl [14];
   logic [15:0] fw [128];

   prog_mem_loader dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_data  (cpu_data),
      .cpu_rst_n (cpu_rst_n),
      .ld_start  (ld_start),
      .ld_valid  (ld_valid),
      .ld_byte   (ld_byte),
      .ld_ready  (ld_ready),
      .ld_done   (ld_done),
      .ld_err    (ld_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rd_check(input string name, input logic [6:0] a, input logic [15:0] exp);
      @(negedge clk);
      cpu_addr = a;
      #1;
      check($sformatf("%s mem[%0d]", name, a), {16'h0, cpu_data}, {16'h0, exp});
   endtask

   task automatic check_stage(input int st);
      for (int i = 0; i < 14; i++)
         if (tbl[i].stage == st) rd_check($sformatf("stage%0d", st), tbl[i].addr, tbl[i].data);
   endtask

   task automatic start_load();
      @(negedge clk);
      ld_start = 1'b1;
      @(posedge clk);
      #1;
      ld_start = 1'b0;
   endtask

   // Returns 1 time unit after the edge that transferred the byte.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit ok = 1'b0;
      @(negedge clk);
      if (gaps && ($urandom_range(0, 1) == 1)) begin
         ld_valid = 1'b0;
         @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_byte  = b;
      for (int k = 0; k < 50; k++) begin
         ok = ld_ready;
         @(posedge clk);
         if (ok) break;
         @(negedge clk);
      end
      #1;
      ld_valid = 1'b0;
      if (!ok) begin
         nvec++;
         nerr++;
         $display("FAIL send_byte timeout: ld_ready stuck at 0, byte %h", b);
      end
   endtask

   task automatic send_frame(input int n, input logic [7:0] bad, input bit gaps);
      logic [7:0] c = 8'h00;
      send_byte((n == 128) ? 8'h00 : 8'(n), gaps);
      for (int i = 0; i < n; i++) begin
         send_byte(fw[i][15:8], gaps);
         send_byte(fw[i][7:0], gaps);
         c = c ^ fw[i][15:8] ^ fw[i][7:0];
      end
      send_byte(c ^ bad, gaps);
   endtask

   initial begin
      tbl[0]  = '{2, 7'd0,   16'h1234};
      tbl[1]  = '{2, 7'd1,   16'hABCD};
      tbl[2]  = '{2, 7'd2,   16'h0000};
      tbl[3]  = '{2, 7'd127, 16'h0000};
      tbl[4]  = '{3, 7'd0,   16'h1234};
      tbl[5]  = '{3, 7'd1,   16'hABCD};
      tbl[6]  = '{5, 7'd0,   16'h1234};
      tbl[7]  = '{5, 7'd1,   16'hABCD};
      tbl[8]  = '{5, 7'd2,   16'h02FD};
      tbl[9]  = '{5, 7'd127, 16'h7F80};
      tbl[10] = '{6, 7'd0,   16'h9ABC};
      tbl[11] = '{6, 7'd1,   16'hABCD};
      tbl[12] = '{6, 7'd2,   16'h02FD};
      tbl[13] = '{9, 7'd0,   16'h0000};

      reset    = 1'b0;
      cpu_addr = '0;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      ld_byte  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // 1: idle after reset
      repeat (10) @(negedge clk);
      check("idle cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
      check("idle ld_ready", {31'h0, ld_ready}, 32'h0);
      for (int a = 0; a < 128; a++) rd_check("idle", 7'(a), 16'h0000);

      // 2: two-word frame, good checksum (0x40)
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      start_load();
      check("start ld_ready", {31'h0, ld_ready}, 32'h1);
      send_frame(2, 8'h00, 1'b0);
      check("t2 rst_n at C edge", {31'h0, cpu_rst_n}, 32'h0);
      @(posedge clk);
      #1;
      check("t2 rst_n one edge later", {31'h0, cpu_rst_n}, 32'h1);
      check("t2 ld_done", {31'h0, ld_done}, 32'h1);
      check("t2 ld_ready in RUN", {31'h0, ld_ready}, 32'h0);
      check_stage(2);

      // 3: same frame, checksum 0x41
      start_load();
      check("t3 ld_done cleared", {31'h0, ld_done}, 32'h0);
      check("t3 rst_n cleared", {31'h0, cpu_rst_n}, 32'h0);
      send_frame(2, 8'h01, 1'b0);
      @(posedge clk);
      #1;
      check("t3 ld_err", {31'h0, ld_err}, 32'h1);
      check("t3 rst_n", {31'h0, cpu_rst_n}, 32'h0);
      check("t3 ld_done", {31'h0, ld_done}, 32'h0);
      check_stage(3);

      // 4: count byte 00 -> 128 words
      for (int i = 0; i < 128; i++) fw[i] = {8'(i), ~8'(i)};
      start_load();
      check("t4 ld_err cleared", {31'h0, ld_err}, 32'h0);
      send_frame(128, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("t4 ld_done", {31'h0, ld_done}, 32'h1);
      check("t4 ld_err", {31'h0, ld_err}, 32'h0);
      for (int a = 0; a < 128; a++) rd_check("t4", 7'(a), {8'(a), ~8'(a)});

      // 5: test-2 frame with random valid gaps
      fw[0] = 16'h1234;
      fw[1] = 16'hABCD;
      start_load();
      send_frame(2, 8'h00, 1'b1);
      check("t5 rst_n at C edge", {31'h0, cpu_rst_n}, 32'h0);
      @(posedge clk);
      #1;
      check("t5 rst_n", {31'h0, cpu_rst_n}, 32'h1);
      check("t5 ld_done", {31'h0, ld_done}, 32'h1);
      check_stage(5);

      // 6: ld_start collides with a data byte in LO; the byte must be dropped
      start_load();
      send_byte(8'h02, 1'b0);
      send_byte(8'h55, 1'b0);
      @(negedge clk);
      ld_start = 1'b1;
      ld_valid = 1'b1;
      ld_byte  = 8'h66;
      @(posedge clk);
      #1;
      ld_start = 1'b0;
      ld_valid = 1'b0;
      check("t6 ld_ready (COUNT)", {31'h0, ld_ready}, 32'h1);
      check("t6 ld_done", {31'h0, ld_done}, 32'h0);
      rd_check("t6 dropped", 7'd0, 16'h1234);
      fw[0] = 16'h9ABC;
      send_frame(1, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("t6 ld_done", {31'h0, ld_done}, 32'h1);
      check("t6 ld_err", {31'h0, ld_err}, 32'h0);
      check_stage(6);

      // 6b: asynchronous reset mid-load
      start_load();
      send_byte(8'h02, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("rst ld_ready", {31'h0, ld_ready}, 32'h0);
      check("rst cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
      check("rst ld_done", {31'h0, ld_done}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("post-rst ld_ready (IDLE)", {31'h0, ld_ready}, 32'h0);
      check_stage(9);
      rd_check("post-rst", 7'd1, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
